norm_shifter: RTL

NORM_SHIFTER -- requirements
Module: norm_shifter

---
 rtl/lzc_pkg.sv | 15 +
 rtl/nib_shift.sv | 16 +
 rtl/norm_shifter.sv | 77 +++++++
 3 files changed

// File: rtl/lzc_pkg.sv
// Constants and stage-1 payload type shared by the leading-zero counter and the
// normalizing shifter.
package lzc_pkg;

    localparam int unsigned DW  = 32;
    localparam int unsigned CW  = 5;
    localparam int unsigned NCW = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    bits;
        logic          zero;
    } s1_payload_t;

endpackage

// File: rtl/nib_shift.sv
// Combinational left shift by a whole number of nibbles (0..28 bits), zero-filled.
module nib_shift
    import lzc_pkg::*;
#(
    parameter int unsigned DW = lzc_pkg::DW
) (
    input  logic [DW-1:0]  data,
    input  logic [NCW-1:0] sel,
    output logic [DW-1:0]  shifted
);

    always_comb begin
        shifted = data << {sel, 2'b00};
    end

endmodule

// File: rtl/norm_shifter.sv
// Two-stage normalizing left shifter: nibble shift in stage 1, bit shift in
// stage 2, with valid/ready handshaking on both sides.
module norm_shifter
    import lzc_pkg::*;
#(
    parameter int unsigned DW = lzc_pkg::DW,
    parameter int unsigned CW = lzc_pkg::CW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    input  logic [CW-1:0] i_nlz,
    input  logic          i_all_zero,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic          o_zero,
    output logic          o_err
);

    logic          s1_valid;
    s1_payload_t   s1_q;
    logic          s2_valid;
    logic [DW-1:0] s2_data;
    logic          s2_zero;

    logic          s1_adv;
    logic          s2_adv;
    logic [DW-1:0] nib_out;

    nib_shift #(.DW(DW)) u_nib_shift (
        .data    (i_data),
        .sel     (i_nlz[CW-1:2]),
        .shifted (nib_out)
    );

    always_comb begin
        s2_adv  = !s2_valid || i_ready;
        s1_adv  = !s1_valid || s2_adv;
        o_ready = s1_adv;
    end

    // All-zero operands are forced to zero here so a bogus count cannot leak data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_adv) begin
            s1_valid     <= i_valid;
            s1_q.data    <= i_all_zero ? '0 : nib_out;
            s1_q.bits    <= i_nlz[1:0];
            s1_q.zero    <= i_all_zero;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_zero  <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            s2_data  <= s1_q.data << s1_q.bits;
            s2_zero  <= s1_q.zero;
        end
    end

    always_comb begin
        o_valid = s2_valid;
        o_data  = s2_data;
        o_zero  = s2_zero;
        o_err   = s2_valid && !s2_zero && !s2_data[DW-1];
    end

endmodule
